// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
// Loads a program into instruction memory from a byte stream while holding
// the CPU in reset, then releases the CPU and hands the memory address port
// over to the CPU fetch address.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   load_start_i           single-cycle load request, length on load_len_i
//   load_len_i             load size in bytes (nonzero, multiple of 4, <= MEM_BYTES)
//   run_i                  single-cycle request to release the CPU (IDLE only)
//   abort_i                cancels a load in progress (ASM or WR)
//   byte_valid_i/byte_i    boot byte stream, handshake with byte_ready_o
//   byte_ready_o           high while assembling a word
//   fetch_pc_i             CPU fetch address, routed to mem_addr_o in IDLE/RUN
//   mem_wren_o/mem_addr_o/mem_wdata_o  instruction memory write port
//   cpu_rst_o              holds the CPU in reset unless in RUN
//   load_done_o            one-cycle pulse in the first RUN cycle after a load
//   load_err_o             one-cycle pulse after a rejected length or an abort
//   state_o                current FSM state (0 IDLE, 1 ASM, 2 WR, 3 RUN)
//
// Byte stream handshake: a byte is consumed on every rising edge where both
// byte_valid_i and byte_ready_o are 1; the sender may hold or drop valid at
// will, and ready never depends on valid.
module imem_load_ctrl #(
    parameter int MEM_BYTES = 16384,
    parameter int LEN_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_start_i,
    input  logic [LEN_W-1:0] load_len_i,
    input  logic             run_i,
    input  logic             abort_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_i,
    output logic             byte_ready_o,
    input  logic [31:0]      fetch_pc_i,
    output logic             mem_wren_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             cpu_rst_o,
    output logic             load_done_o,
    output logic             load_err_o,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ASM  = 2'd1,
        ST_WR   = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t           state_q;
    logic [31:0]      ptr_q;
    logic [1:0]       cnt_q;
    logic [31:0]      word_q;
    logic [LEN_W-1:0] len_q;
    logic             done_q;
    logic             err_q;

    logic             len_ok;
    logic             byte_fire;
    logic [31:0]      ptr_next;

    assign len_ok = (load_len_i != '0) &&
                    (load_len_i[1:0] == 2'b00) &&
                    (32'(load_len_i) <= 32'(MEM_BYTES));

    assign byte_fire = byte_ready_o && byte_valid_i;
    assign ptr_next  = ptr_q + 32'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A load request wins over run_i even if its length is bad.
                    if (load_start_i) begin
                        if (len_ok) begin
                            state_q <= ST_ASM;
                            ptr_q   <= '0;
                            cnt_q   <= '0;
                            word_q  <= '0;
                            len_q   <= load_len_i;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (run_i) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_ASM: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else if (byte_fire) begin
                        word_q[{cnt_q, 3'b000} +: 8] <= byte_i;
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (abort_i) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        ptr_q <= ptr_next;
                        // Length is a multiple of 4, so the pointer lands on it exactly.
                        if (ptr_next == 32'(len_q)) begin
                            state_q <= ST_RUN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ASM;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_start_i) begin
                        if (len_ok) begin
                            state_q <= ST_ASM;
                            ptr_q   <= '0;
                            cnt_q   <= '0;
                            word_q  <= '0;
                            len_q   <= load_len_i;
                        end else begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Reset and abort are folded in so nothing is written or consumed in
    // the cycle they are asserted.
    assign byte_ready_o = !rst_i && !abort_i && (state_q == ST_ASM);
    assign mem_wren_o   = !rst_i && !abort_i && (state_q == ST_WR);
    assign cpu_rst_o    = rst_i || (state_q != ST_RUN);
    assign load_done_o  = !rst_i && done_q;
    assign load_err_o   = !rst_i && err_q;
    assign mem_addr_o   = (rst_i || state_q == ST_IDLE || state_q == ST_RUN) ?
                          fetch_pc_i : ptr_q;
    assign mem_wdata_o  = word_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: every memory write seen on the port is
// matched against an expected queue of {addr, data} pairs built by the tests.
module tb_imem_load_ctrl;

    localparam int MEM_BYTES = 16384;
    localparam int LEN_W     = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ASM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd3;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             load_start_i;
    logic [LEN_W-1:0] load_len_i;
    logic             run_i;
    logic             abort_i;
    logic             byte_valid_i;
    logic [7:0]       byte_i;
    logic             byte_ready_o;
    logic [31:0]      fetch_pc_i;
    logic             mem_wren_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             cpu_rst_o;
    logic             load_done_o;
    logic             load_err_o;
    logic [1:0]       state_o;

    int               n_vec = 0;
    int               n_err = 0;
    logic [63:0]      exp_q[$];

    imem_load_ctrl #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_start_i (load_start_i),
        .load_len_i   (load_len_i),
        .run_i        (run_i),
        .abort_i      (abort_i),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .byte_ready_o (byte_ready_o),
        .fetch_pc_i   (fetch_pc_i),
        .mem_wren_o   (mem_wren_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_rst_o    (cpu_rst_o),
        .load_done_o  (load_done_o),
        .load_err_o   (load_err_o),
        .state_o      (state_o)
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Write scoreboard
    always @(negedge clk_i) begin
        if (mem_wren_o === 1'b1) begin
            if (exp_q.size() == 0)
                check("unexpected_write", {mem_addr_o, mem_wdata_o}, 64'hx);
            else
                check("write", {mem_addr_o, mem_wdata_o}, exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_load(input logic [LEN_W-1:0] len);
        load_start_i = 1'b1;
        load_len_i   = len;
        cyc();
        load_start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok           = 1'b0;
        byte_i       = b;
        byte_valid_i = 1'b1;
        for (int n = 0; n < 10 && !ok; n++) begin
            @(negedge clk_i);
            ok = byte_ready_o;
            cyc();
        end
        byte_valid_i = 1'b0;
        if (!ok) check("byte_timeout", 64'(ok), 64'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    logic [7:0] basic_bytes [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [LEN_W-1:0] bad_lens [3] = '{16'd0, 16'd6, 16'(MEM_BYTES + 4)};

    initial begin
        rst_i = 1'b1; load_start_i = 1'b0; load_len_i = '0; run_i = 1'b0;
        abort_i = 1'b0; byte_valid_i = 1'b0; byte_i = '0; fetch_pc_i = 32'h0000_1234;

        // Reset values
        cyc();
        @(negedge clk_i);
        check("rst_cpu_rst", 64'(cpu_rst_o), 64'd1);
        check("rst_wren", 64'(mem_wren_o), 64'd0);
        check("rst_ready", 64'(byte_ready_o), 64'd0);
        check("rst_done_err", 64'({load_done_o, load_err_o}), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'h1234);
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_state", 64'(state_o), 64'(S_IDLE));
        cyc();

        // Basic 8-byte load
        exp_q.push_back({32'd0, 32'h0000_0013});
        exp_q.push_back({32'd4, 32'h0010_0093});
        start_load(16'd8);
        for (int i = 0; i < 8; i++) send_byte(basic_bytes[i]);
        cyc();
        fetch_pc_i = 32'h0000_0040;
        @(negedge clk_i);
        check("basic_state", 64'(state_o), 64'(S_RUN));
        check("basic_done", 64'(load_done_o), 64'd1);
        check("basic_cpu_rst", 64'(cpu_rst_o), 64'd0);
        check("basic_fetch_addr", 64'(mem_addr_o), 64'h40);
        cyc();
        @(negedge clk_i);
        check("basic_done_pulse", 64'(load_done_o), 64'd0);
        check("basic_left", 64'(exp_q.size()), 64'd0);

        // Stalled stream, reload from RUN
        exp_q.push_back({32'd0, 32'hDDCC_BBAA});
        start_load(16'd4);
        send_byte(8'hAA); cyc(); cyc();
        send_byte(8'hBB); cyc(); cyc();
        send_byte(8'hCC); cyc(); cyc();
        send_byte(8'hDD);
        cyc();
        @(negedge clk_i);
        check("stall_state", 64'(state_o), 64'(S_RUN));
        check("stall_done", 64'(load_done_o), 64'd1);
        check("stall_left", 64'(exp_q.size()), 64'd0);

        // Rejected lengths
        do_reset();
        for (int i = 0; i < 3; i++) begin
            start_load(bad_lens[i]);
            @(negedge clk_i);
            check($sformatf("badlen%0d_err", i), 64'(load_err_o), 64'd1);
            check($sformatf("badlen%0d_state", i), 64'(state_o), 64'(S_IDLE));
            cyc();
            @(negedge clk_i);
            check($sformatf("badlen%0d_pulse", i), 64'(load_err_o), 64'd0);
        end

        // Abort in the WR cycle of word 2 of a 12-byte load
        exp_q.push_back({32'd0, 32'h0403_0201});
        start_load(16'd12);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        abort_i = 1'b1;
        @(negedge clk_i);
        check("abort_wren", 64'(mem_wren_o), 64'd0);
        cyc();
        abort_i = 1'b0;
        @(negedge clk_i);
        check("abort_state", 64'(state_o), 64'(S_IDLE));
        check("abort_err", 64'(load_err_o), 64'd1);
        check("abort_cpu_rst", 64'(cpu_rst_o), 64'd1);
        check("abort_left", 64'(exp_q.size()), 64'd0);
        cyc();

        // Reset after 3 bytes of a word
        start_load(16'd4);
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_ready", 64'(byte_ready_o), 64'd0);
        check("midrst_wren", 64'(mem_wren_o), 64'd0);
        cyc();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_state", 64'(state_o), 64'(S_IDLE));
        check("midrst_ready_after", 64'(byte_ready_o), 64'd0);
        cyc();
        exp_q.push_back({32'd0, 32'h4433_2211});
        start_load(16'd4);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        cyc();
        @(negedge clk_i);
        check("midrst_reload_state", 64'(state_o), 64'(S_RUN));
        check("midrst_left", 64'(exp_q.size()), 64'd0);

        // load_start and run together in IDLE
        do_reset();
        run_i = 1'b1; load_start_i = 1'b1; load_len_i = 16'd4;
        cyc();
        run_i = 1'b0; load_start_i = 1'b0;
        @(negedge clk_i);
        check("prio_state", 64'(state_o), 64'(S_ASM));
        check("prio_ready", 64'(byte_ready_o), 64'd1);
        check("prio_cpu_rst", 64'(cpu_rst_o), 64'd1);
        abort_i = 1'b1;
        cyc();
        abort_i = 1'b0;
        @(negedge clk_i);
        check("prio_abort_err", 64'(load_err_o), 64'd1);

        // run_i alone releases the CPU without a load
        cyc();
        run_i = 1'b1;
        cyc();
        run_i = 1'b0;
        fetch_pc_i = 32'h0000_0100;
        @(negedge clk_i);
        check("run_state", 64'(state_o), 64'(S_RUN));
        check("run_cpu_rst", 64'(cpu_rst_o), 64'd0);
        check("run_no_done", 64'(load_done_o), 64'd0);
        check("run_addr", 64'(mem_addr_o), 64'h100);

        cyc(); cyc();
        check("final_left", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
